beep_scheduler: RTL and testbench
=================================

BEEP_SCHEDULER -- requirements
Module: beep_scheduler

Interface
REQ-001 Parameter HALF_P5, default 25_000_000, SHALL set the half-period in clk cycles for zone 5 (distance == 5).
REQ-002 Parameter HALF_P4, default 12_500_000, SHALL set the zone 4 half-period (distance == 4).
REQ-003 Parameter HALF_P3, default 6_250_000, SHALL set the zone 3 half-period (distance == 3).
REQ-004 Parameter HALF_P2, default 3_125_000, SHALL set the zone 2 half-period (distance <= 2).
REQ-005 Parameter STABLE_CNT, default 3, range 1..15, SHALL set the number of consecutive matching samples needed to change zone.
REQ-006 clk  input  1  SHALL be the single system clock; all state is updated on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-008 distance  input  8  SHALL carry the unsigned distance sample, qualified by distance_valid.
REQ-009 distance_valid  input  1  SHALL be a one-cycle strobe marking a new distance sample.
REQ-010 overload  input  1  SHALL be a level request for a continuous tone, with priority over distance beeping.
REQ-011 mute  input  1  SHALL be a level that silences distance beeping only; it does not silence overload.
REQ-012 alarm  output  1  SHALL be the registered buzzer drive.
REQ-013 zone  output  3  SHALL be the registered active zone: 0 = off, 1 = d5, 2 = d4, 3 = d3, 4 = d<=2.

Function
REQ-014 The candidate zone SHALL be computed from distance as follows: >= 6 -> 0; 5 -> 1; 4 -> 2; 3 -> 3; 0..2 -> 4.
REQ-015 On each distance_valid, a candidate equal to pending_zone SHALL increment match_cnt (saturating at STABLE_CNT); otherwise pending_zone <= candidate and match_cnt <= 1.
REQ-016 zone SHALL be loaded with pending_zone on the clock edge after match_cnt equals STABLE_CNT, giving 1-cycle latency after the qualifying sample.
REQ-017 Cycles without distance_valid SHALL NOT alter pending_zone, match_cnt or zone.
REQ-018 The FSM SHALL have four states: IDLE, ON, OFF, CONT.
REQ-019 IDLE: alarm = 0, phase counter = 0; go to CONT if overload, else to ON if zone != 0 and mute = 0.
REQ-020 ON: alarm = 1; the phase counter SHALL count 0..half-1, then go to OFF with the counter cleared.
REQ-021 OFF: alarm = 0; the phase counter SHALL count 0..half-1, then go to ON with the counter cleared.
REQ-022 half SHALL be latched from zone on entry to each ON and OFF phase, so a zone change between nonzero zones takes effect at the next phase boundary without truncating the current phase.
REQ-023 From ON or OFF, zone == 0 or mute == 1 SHALL force IDLE on the next edge, so alarm = 0 one cycle later.
REQ-024 overload SHALL force CONT from any state on the next edge; CONT drives alarm = 1 continuously.
REQ-025 Deasserting overload SHALL return the FSM from CONT to IDLE, and distance beeping restarts from an ON phase.
REQ-026 Simultaneous overload and mute SHALL give CONT.
REQ-027 alarm SHALL be a registered decode of state, so it is glitch-free.
REQ-028 The phase counter SHALL be 26 bits wide and SHALL never wrap, since each comparison is against half-1.

Reset
REQ-029 While rst = 1, state = IDLE, alarm = 0, zone = 0, pending_zone = 0, match_cnt = 0 and phase counter = 0, asynchronously.
REQ-030 Reset asserted mid-phase or mid-debounce SHALL discard all progress; after release, STABLE_CNT new samples are required before beeping.

Verification (HALF_P5 = 8, HALF_P4 = 6, HALF_P3 = 4, HALF_P2 = 2, STABLE_CNT = 3)
REQ-031 Three valid samples of distance = 5 -> zone = 1 one cycle after the third sample; alarm alternates 8 cycles high and 8 cycles low, starting high.
REQ-032 Samples 5, 5, 3, 5, 5 -> zone stays 0; one further 5 -> zone = 1.
REQ-033 Zone 1 beeping, then three samples of 1 during an ON phase -> the current 8-cycle high completes, then 2-low/2-high cadence.
REQ-034 Beeping in zone 4, mute asserted -> alarm = 0 on the next cycle; overload then asserted -> alarm = 1 steady; overload released -> alarm = 0 while mute is held.
REQ-035 rst pulsed during an ON phase -> alarm = 0 and zone = 0 immediately; no beep until three new matching samples arrive.
REQ-036 Three samples of distance = 200, then three of 0 -> zone goes 0 -> 4; alarm starts 2-cycle toggling one cycle after zone updates.

Source files
------------

// File: rtl/beep_scheduler.sv
// ---------------------------------------------------------------------------
// beep_scheduler
//   Parking-sensor style buzzer scheduler. Distance samples are debounced into
//   a zone (0 = off, 1 = d5, 2 = d4, 3 = d3, 4 = d<=2). Each nonzero zone
//   selects a beep half-period. An overload request gives a continuous tone
//   with priority over everything. Mute silences distance beeping only.
//
// Parameters
//   HALF_P5/P4/P3/P2 : half-period in clk cycles for zones 1/2/3/4
//   STABLE_CNT       : consecutive matching samples needed to change zone (1..15)
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   distance       : unsigned distance sample, qualified by distance_valid
//   distance_valid : one-cycle strobe marking a new sample
//   overload       : level, continuous tone request
//   mute           : level, silences distance beeping only
//   alarm          : registered buzzer drive
//   zone           : registered active zone
// ---------------------------------------------------------------------------
module beep_scheduler #(
  parameter int unsigned HALF_P5    = 25_000_000,
  parameter int unsigned HALF_P4    = 12_500_000,
  parameter int unsigned HALF_P3    = 6_250_000,
  parameter int unsigned HALF_P2    = 3_125_000,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] distance,
  input  logic       distance_valid,
  input  logic       overload,
  input  logic       mute,
  output logic       alarm,
  output logic [2:0] zone
);

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    CONT
  } state_t;

  state_t      state;
  logic [2:0]  candidate;
  logic [2:0]  pending_zone;
  logic [3:0]  match_cnt;
  logic [25:0] phase_cnt;
  logic [25:0] half_m1;
  logic [25:0] zone_half_m1;
  logic        beep_allowed;

  // Distance to candidate zone.
  always_comb begin
    candidate = 3'd0;
    if (distance >= 8'd6)      candidate = 3'd0;
    else if (distance == 8'd5) candidate = 3'd1;
    else if (distance == 8'd4) candidate = 3'd2;
    else if (distance == 8'd3) candidate = 3'd3;
    else                       candidate = 3'd4;
  end

  // Half-period (minus one) of the currently active zone; latched at each
  // phase entry so a zone change never truncates a running phase.
  always_comb begin
    zone_half_m1 = '0;
    case (zone)
      3'd1:    zone_half_m1 = 26'(HALF_P5 - 1);
      3'd2:    zone_half_m1 = 26'(HALF_P4 - 1);
      3'd3:    zone_half_m1 = 26'(HALF_P3 - 1);
      3'd4:    zone_half_m1 = 26'(HALF_P2 - 1);
      default: zone_half_m1 = '0;
    endcase
  end

  assign beep_allowed = (zone != 3'd0) && !mute;

  // Debounce: zone follows pending_zone one edge after the match count
  // reaches STABLE_CNT. Cycles without a strobe leave everything untouched;
  // once matched, reloading zone with the same pending value is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_zone <= '0;
      match_cnt    <= '0;
      zone         <= '0;
    end else begin
      if (match_cnt == STABLE) zone <= pending_zone;
      if (distance_valid) begin
        if (candidate == pending_zone) begin
          if (match_cnt != STABLE) match_cnt <= match_cnt + 4'd1;
        end else begin
          pending_zone <= candidate;
          match_cnt    <= 4'd1;
        end
      end
    end
  end

  // Beep FSM; alarm is registered alongside the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      alarm     <= 1'b0;
      phase_cnt <= '0;
      half_m1   <= '0;
    end else if (overload) begin
      state     <= CONT;
      alarm     <= 1'b1;
      phase_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (beep_allowed) begin
            state   <= ON;
            alarm   <= 1'b1;
            half_m1 <= zone_half_m1;
          end else begin
            alarm <= 1'b0;
          end
        end
        ON: begin
          if (!beep_allowed) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            phase_cnt <= '0;
          end else if (phase_cnt == half_m1) begin
            state     <= OFF;
            alarm     <= 1'b0;
            phase_cnt <= '0;
            half_m1   <= zone_half_m1;
          end else begin
            alarm     <= 1'b1;
            phase_cnt <= phase_cnt + 26'd1;
          end
        end
        OFF: begin
          if (!beep_allowed) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            phase_cnt <= '0;
          end else if (phase_cnt == half_m1) begin
            state     <= ON;
            alarm     <= 1'b1;
            phase_cnt <= '0;
            half_m1   <= zone_half_m1;
          end else begin
            alarm     <= 1'b0;
            phase_cnt <= phase_cnt + 26'd1;
          end
        end
        CONT: begin
          state     <= IDLE;
          alarm     <= 1'b0;
          phase_cnt <= '0;
        end
        default: begin
          state     <= IDLE;
          alarm     <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_beep_scheduler
//   Randomized bench for beep_scheduler with a small behavioural model:
//   debounce as a run length of identical candidates, beeping as a
//   level + remaining-cycles countdown. alarm and zone are compared every
//   cycle on the falling edge; reset is pulsed asynchronously mid-run.
// ---------------------------------------------------------------------------
module tb_beep_scheduler;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] distance = '0;
  logic       distance_valid = 1'b0;
  logic       overload = 1'b0;
  logic       mute = 1'b0;
  logic       alarm;
  logic [2:0] zone;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_pend, m_run, m_zone;
  bit m_cont, m_active, m_level, m_alarm;
  int m_remain;

  beep_scheduler #(
    .HALF_P5   (8),
    .HALF_P4   (6),
    .HALF_P3   (4),
    .HALF_P2   (2),
    .STABLE_CNT(S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .distance      (distance),
    .distance_valid(distance_valid),
    .overload      (overload),
    .mute          (mute),
    .alarm         (alarm),
    .zone          (zone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int zone_of(input int d);
    if (d >= 6) return 0;
    if (d == 5) return 1;
    if (d == 4) return 2;
    if (d == 3) return 3;
    return 4;
  endfunction

  function automatic int half_of(input int z);
    case (z)
      1: return 8;
      2: return 6;
      3: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_run = 0; m_zone = 0;
    m_cont = 0; m_active = 0; m_level = 0; m_alarm = 0; m_remain = 0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_step();
    int old_zone;
    if (rst) begin
      model_reset();
      return;
    end
    old_zone = m_zone;
    if (m_run >= S) m_zone = m_pend;
    if (distance_valid) begin
      if (zone_of(int'(distance)) == m_pend) m_run++;
      else begin
        m_pend = zone_of(int'(distance));
        m_run  = 1;
      end
    end
    if (overload) begin
      m_cont = 1; m_active = 0; m_alarm = 1;
    end else if (m_cont) begin
      m_cont = 0; m_alarm = 0;
    end else if (!m_active) begin
      if (old_zone != 0 && !mute) begin
        m_active = 1; m_level = 1; m_remain = half_of(old_zone); m_alarm = 1;
      end else m_alarm = 0;
    end else begin
      if (old_zone == 0 || mute) begin
        m_active = 0; m_alarm = 0;
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          m_level  = !m_level;
          m_remain = half_of(old_zone);
        end
        m_alarm = m_level;
      end
    end
  endtask

  int target;

  initial begin
    model_reset();
    #2;
    check("reset_alarm", int'(alarm), 0);
    check("reset_zone", int'(zone), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    target = 5;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      model_step();
      #2;
      // new stimulus
      if (rst) rst = 1'b0;
      if (cyc % 70 == 0) begin
        case ($urandom_range(0, 6))
          0: target = 200;
          1: target = 0;
          default: target = int'($urandom_range(1, 7));
        endcase
      end
      distance_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) < 85) distance = 8'(target);
      else distance = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 119) == 0) mute = ~mute;
      if (overload) begin
        if ($urandom_range(0, 9) == 0) overload = 1'b0;
      end else if ($urandom_range(0, 179) == 0) overload = 1'b1;
      if ($urandom_range(0, 399) == 0) begin
        // asynchronous reset pulse: outputs must clear without a clock edge
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_alarm", int'(alarm), 0);
        check("async_rst_zone", int'(zone), 0);
      end
      @(negedge clk);
      check("alarm", int'(alarm), int'(m_alarm));
      check("zone", int'(zone), m_zone);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
